// File: rtl/rf_writeback_ctrl.sv
// Write-back stage and register-file port controller: MEM/WB entry,
// one-hot write/read enables, write bypass and per-register scoreboard.
// Ports: clk, rst; issue_valid/issue_dst from decode; mw_* MEM result;
// wb_stall, flush; rd_src1/2 read addresses; WriteReg/D write port;
// ReadEnable1/2 read ports; byp1_en/byp2_en/byp_data bypass;
// src_hazard decode stall; sb_err sticky scoreboard error.
module rf_writeback_ctrl #(
  parameter int NREG = 16,
  parameter int DW   = 16,
  parameter int CW   = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_dst,
  input  logic          mw_valid,
  input  logic          mw_wr,
  input  logic [AW-1:0] mw_dst,
  input  logic [DW-1:0] mw_data,
  input  logic          wb_stall,
  input  logic          flush,
  input  logic [AW-1:0] rd_src1,
  input  logic [AW-1:0] rd_src2,
  output logic [NREG-1:0] WriteReg,
  output logic [DW-1:0]   D,
  output logic [NREG-1:0] ReadEnable1,
  output logic [NREG-1:0] ReadEnable2,
  output logic            byp1_en,
  output logic            byp2_en,
  output logic [DW-1:0]   byp_data,
  output logic            src_hazard,
  output logic            sb_err
);

  typedef struct packed {
    logic          valid;
    logic          wr;
    logic [AW-1:0] dst;
    logic [DW-1:0] data;
  } wb_t;

  localparam logic [CW-1:0] CMAX = '1;

  wb_t           wb;
  logic [CW-1:0] cnt [NREG];
  logic          wfire;
  logic          haz1;
  logic          haz2;

  // A stalled entry keeps dst/data but drops valid so it writes once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb <= '0;
    end else if (flush) begin
      wb.valid <= 1'b0;
    end else if (!wb_stall) begin
      wb <= '{mw_valid, mw_wr, mw_dst, mw_data};
    end else begin
      wb.valid <= 1'b0;
    end
  end

  assign wfire = wb.valid & wb.wr & (wb.dst != '0);

  assign WriteReg    = wfire ? (NREG'(1) << wb.dst) : '0;
  assign D           = wb.data;
  assign byp_data    = wb.data;
  assign ReadEnable1 = NREG'(1) << rd_src1;
  assign ReadEnable2 = NREG'(1) << rd_src2;

  assign byp1_en = wfire & (rd_src1 == wb.dst) & (rd_src1 != '0);
  assign byp2_en = wfire & (rd_src2 == wb.dst) & (rd_src2 != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      sb_err <= 1'b0;
    end else if (flush) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
        logic inc;
        logic dec;
        inc = issue_valid & (issue_dst == AW'(r));
        dec = wfire & (wb.dst == AW'(r));
        unique case (1'b1)
          inc & ~dec: begin
            if (cnt[r] == CMAX) sb_err <= 1'b1;
            else cnt[r] <= cnt[r] + 1'b1;
          end
          dec & ~inc: begin
            if (cnt[r] == '0) sb_err <= 1'b1;
            else cnt[r] <= cnt[r] - 1'b1;
          end
          default: cnt[r] <= cnt[r];
        endcase
      end
    end
  end

  // The write being bypassed already covers one pending count.
  assign haz1 = (rd_src1 != '0) &
                (cnt[rd_src1] > (byp1_en ? CW'(1) : CW'(0)));
  assign haz2 = (rd_src2 != '0) &
                (cnt[rd_src2] > (byp2_en ? CW'(1) : CW'(0)));
  assign src_hazard = haz1 | haz2;

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Randomized and directed bench for rf_writeback_ctrl against a
// behavioural model of the write-back entry and pending-write counts.
module tb_rf_writeback_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [3:0]  issue_dst;
  logic        mw_valid;
  logic        mw_wr;
  logic [3:0]  mw_dst;
  logic [15:0] mw_data;
  logic        wb_stall;
  logic        flush;
  logic [3:0]  rd_src1;
  logic [3:0]  rd_src2;
  logic [15:0] WriteReg;
  logic [15:0] D;
  logic [15:0] ReadEnable1;
  logic [15:0] ReadEnable2;
  logic        byp1_en;
  logic        byp2_en;
  logic [15:0] byp_data;
  logic        src_hazard;
  logic        sb_err;

  rf_writeback_ctrl dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_dst(issue_dst),
    .mw_valid(mw_valid), .mw_wr(mw_wr),
    .mw_dst(mw_dst), .mw_data(mw_data),
    .wb_stall(wb_stall), .flush(flush),
    .rd_src1(rd_src1), .rd_src2(rd_src2),
    .WriteReg(WriteReg), .D(D),
    .ReadEnable1(ReadEnable1), .ReadEnable2(ReadEnable2),
    .byp1_en(byp1_en), .byp2_en(byp2_en),
    .byp_data(byp_data), .src_hazard(src_hazard),
    .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit          m_valid;
  bit          m_wr;
  int          m_dst;
  logic [15:0] m_data;
  int          m_cnt [16];
  bit          m_err;
  logic [15:0] obs_wr;
  int          pulses;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 0; issue_dst = 0;
    mw_valid = 0; mw_wr = 0; mw_dst = 0; mw_data = 0;
    wb_stall = 0; flush = 0;
    rd_src1 = 0; rd_src2 = 0;
  endtask

  task automatic model_reset();
    m_valid = 0; m_wr = 0; m_dst = 0; m_data = 0; m_err = 0;
    for (int r = 0; r < 16; r++) m_cnt[r] = 0;
  endtask

  // Called just after a falling edge; reset takes effect immediately.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_wr", WriteReg, 0);
    check("rst_d", D, 0);
    check("rst_byp", {byp1_en, byp2_en}, 0);
    check("rst_haz", src_hazard, 0);
    check("rst_err", sb_err, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Check outputs for current inputs, then advance one clock.
  task automatic cyc();
    bit fire, b1, b2, haz, n_err;
    int n_cnt [16];
    int d, n;
    #1;
    fire = m_valid && m_wr && m_dst != 0;
    b1 = fire && int'(rd_src1) == m_dst && rd_src1 != 0;
    b2 = fire && int'(rd_src2) == m_dst && rd_src2 != 0;
    haz = (rd_src1 != 0 && m_cnt[rd_src1] > (b1 ? 1 : 0)) ||
          (rd_src2 != 0 && m_cnt[rd_src2] > (b2 ? 1 : 0));
    obs_wr = WriteReg;
    check("wr", WriteReg, fire ? 2 ** m_dst : 0);
    check("d", D, m_data);
    check("re1", ReadEnable1, 2 ** int'(rd_src1));
    check("re2", ReadEnable2, 2 ** int'(rd_src2));
    check("byp1", byp1_en, b1);
    check("byp2", byp2_en, b2);
    check("bypd", byp_data, m_data);
    check("haz", src_hazard, haz);
    check("err", sb_err, m_err);
    n_err = m_err;
    for (int r = 0; r < 16; r++) begin
      n_cnt[r] = m_cnt[r];
      if (flush) n_cnt[r] = 0;
      else if (r != 0) begin
        d = ((issue_valid && int'(issue_dst) == r) ? 1 : 0) -
            ((fire && m_dst == r) ? 1 : 0);
        n = m_cnt[r] + d;
        if (n < 0 || n > 3) n_err = 1;
        else n_cnt[r] = n;
      end
    end
    @(posedge clk);
    if (flush) m_valid = 0;
    else if (!wb_stall) begin
      m_valid = mw_valid; m_wr = mw_wr;
      m_dst = int'(mw_dst); m_data = mw_data;
    end else m_valid = 0;
    m_err = n_err;
    for (int r = 0; r < 16; r++) m_cnt[r] = n_cnt[r];
    @(negedge clk);
  endtask

  task automatic mw(input logic [3:0] dst, input logic [15:0] dat);
    mw_valid = 1; mw_wr = 1; mw_dst = dst; mw_data = dat;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    do_reset();

    mw(5, 16'hBEEF);
    cyc();
    idle();
    check("t1_wr", WriteReg, 16'h0020);
    check("t1_d", D, 16'hBEEF);
    cyc();
    check("t1_once", WriteReg, 16'h0000);

    mw(0, 16'h1234);
    cyc();
    idle();
    rd_src2 = 0;
    cyc();
    check("t2_wr0", WriteReg, 0);
    check("t2_re0", ReadEnable1, 16'h0001);

    issue_valid = 1; issue_dst = 3;
    mw(3, 16'h1111);
    cyc();
    idle();
    rd_src1 = 3; rd_src2 = 3;
    #1;
    check("t3_byp", {byp1_en, byp2_en}, 2'b11);
    check("t3_bypd", byp_data, 16'h1111);
    check("t3_haz", src_hazard, 0);
    cyc();
    idle();

    issue_valid = 1; issue_dst = 7;
    cyc();
    mw(7, 16'h7777);
    cyc();
    idle();
    rd_src1 = 7;
    #1;
    check("t4_haz2", src_hazard, 1);
    cyc();
    check("t4_haz1", src_hazard, 1);
    cyc();

    idle();
    issue_valid = 1; issue_dst = 4;
    mw(4, 16'h4444);
    cyc();
    issue_valid = 1; issue_dst = 4;
    mw_valid = 0;
    cyc();
    idle();
    rd_src1 = 4;
    #1;
    check("t5_cnt4", src_hazard, 1);
    cyc();
    idle();
    issue_valid = 1; issue_dst = 9;
    repeat (4) cyc();
    idle();
    check("t5_err", sb_err, 1);
    rd_src1 = 9;
    cyc();
    do_reset();

    mw(6, 16'h6666);
    cyc();
    idle();
    wb_stall = 1;
    mw(6, 16'h6666);
    pulses = 0;
    repeat (3) begin
      cyc();
      if (obs_wr != 0) pulses++;
    end
    check("t6_pulses", pulses, 1);
    idle();
    issue_valid = 1; issue_dst = 10;
    cyc();
    issue_dst = 11;
    cyc();
    idle();
    flush = 1;
    issue_valid = 1; issue_dst = 12;
    mw(10, 16'hAAAA);
    cyc();
    idle();
    rd_src1 = 10; rd_src2 = 12;
    #1;
    check("t6_flush_haz", src_hazard, 0);
    check("t6_flush_wr", WriteReg, 0);
    cyc();
    mw(8, 16'h8888);
    cyc();
    idle();
    wb_stall = 1;
    do_reset();
    idle();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        issue_valid = ($urandom_range(0, 2) == 0);
        issue_dst   = 4'($urandom_range(0, 15));
        mw_valid    = ($urandom_range(0, 1) == 0);
        mw_wr       = ($urandom_range(0, 3) != 0);
        mw_dst      = 4'($urandom_range(0, 15));
        mw_data     = 16'($urandom);
        wb_stall    = ($urandom_range(0, 7) == 0);
        flush       = ($urandom_range(0, 31) == 0);
        rd_src1     = 4'($urandom_range(0, 15));
        rd_src2     = ($urandom_range(0, 3) == 0) ?
                      mw_dst : 4'($urandom_range(0, 15));
        cyc();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
